// File: rtl/timer_bus_arbiter.sv
// timer_bus_arbiter
//   Shares the single register port of the RRIOT interval timer between two
//   requesters. m0 (CPU bus) has priority; m1 (debug/host) gets forced through
//   after MAX_WAIT consecutive lost arbitrations (MAX_WAIT = 0 gives strict m0
//   priority). Each access is a one-cycle write strobe or a two-cycle read that
//   matches the timer's registered DO, followed by a single-cycle ack.
//
// Ports
//   clk, rst_n                 clock (rising edge), async active-low reset
//   mX_req                     level request, fields stable until mX_ack
//   mX_we_n                    0 = write, 1 = read
//   mX_addr[2:0], mX_wdata[7:0] timer address and write data
//   mX_ack                     one-cycle completion pulse
//   mX_rdata[7:0]              read data, valid with mX_ack, held until next read
//   tmr_we_n, tmr_a, tmr_di    timer register port (outputs)
//   tmr_do                     timer read data, registered one cycle after tmr_a
//   busy                       high whenever the sequencer is not idle
//   grant_id                   owner of the current or last access (0 = m0)
module timer_bus_arbiter #(
  parameter int MAX_WAIT = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       m0_req,
  input  logic       m0_we_n,
  input  logic [2:0] m0_addr,
  input  logic [7:0] m0_wdata,
  output logic       m0_ack,
  output logic [7:0] m0_rdata,
  input  logic       m1_req,
  input  logic       m1_we_n,
  input  logic [2:0] m1_addr,
  input  logic [7:0] m1_wdata,
  output logic       m1_ack,
  output logic [7:0] m1_rdata,
  output logic       tmr_we_n,
  output logic [2:0] tmr_a,
  output logic [7:0] tmr_di,
  input  logic [7:0] tmr_do,
  output logic       busy,
  output logic       grant_id
);

  // A zero-width counter is not legal, so strict mode keeps one idle bit.
  localparam int WCW = (MAX_WAIT > 0) ? $clog2(MAX_WAIT + 1) : 1;
  localparam logic [WCW-1:0] WAIT_MAX = WCW'(MAX_WAIT);

  typedef enum logic [2:0] {
    IDLE,
    WR,
    RD_ADDR,
    RD_WAIT,
    ACK
  } state_t;

  state_t         state_reg, state_next;
  logic           grant_next;
  logic [WCW-1:0] wait_cnt_reg, wait_cnt_next;
  logic           tmr_we_n_next;
  logic [2:0]     tmr_a_next;
  logic [7:0]     tmr_di_next;
  logic [1:0]     ack_next;
  logic [1:0]     rdata_load;
  logic           busy_next;
  logic           winner;
  logic           sel_we_n;
  logic [2:0]     sel_addr;
  logic [7:0]     sel_wdata;

  always_comb begin
    state_next    = state_reg;
    grant_next    = grant_id;
    wait_cnt_next = wait_cnt_reg;
    tmr_we_n_next = 1'b1;
    // Address and data hold their last granted values so any read-side
    // side effect in the timer only repeats the access just performed.
    tmr_a_next    = tmr_a;
    tmr_di_next   = tmr_di;
    ack_next      = 2'b00;
    rdata_load    = 2'b00;
    winner        = m1_req && (!m0_req || ((MAX_WAIT != 0) && (wait_cnt_reg == WAIT_MAX)));
    sel_we_n      = winner ? m1_we_n  : m0_we_n;
    sel_addr      = winner ? m1_addr  : m0_addr;
    sel_wdata     = winner ? m1_wdata : m0_wdata;

    case (state_reg)
      IDLE: begin
        if (!m1_req) begin
          wait_cnt_next = '0;
        end
        if (m0_req || m1_req) begin
          grant_next  = winner;
          tmr_a_next  = sel_addr;
          tmr_di_next = sel_wdata;
          if (winner) begin
            wait_cnt_next = '0;
          end else if (m1_req && (wait_cnt_reg != WAIT_MAX)) begin
            wait_cnt_next = wait_cnt_reg + 1'b1;
          end
          if (!sel_we_n) begin
            tmr_we_n_next = 1'b0;
            state_next    = WR;
          end else begin
            state_next    = RD_ADDR;
          end
        end
      end
      WR: begin
        ack_next[grant_id] = 1'b1;
        state_next         = ACK;
      end
      // The timer registers DO on the edge that leaves this state.
      RD_ADDR: state_next = RD_WAIT;
      RD_WAIT: begin
        rdata_load[grant_id] = 1'b1;
        ack_next[grant_id]   = 1'b1;
        state_next           = ACK;
      end
      ACK:     state_next = IDLE;
      default: state_next = IDLE;
    endcase

    busy_next = (state_next != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= IDLE;
      grant_id     <= 1'b0;
      wait_cnt_reg <= '0;
      tmr_we_n     <= 1'b1;
      tmr_a        <= 3'b001;  // irq-flag read: harmless while parked
      tmr_di       <= 8'h00;
      m0_ack       <= 1'b0;
      m1_ack       <= 1'b0;
      m0_rdata     <= 8'h00;
      m1_rdata     <= 8'h00;
      busy         <= 1'b0;
    end else begin
      state_reg    <= state_next;
      grant_id     <= grant_next;
      wait_cnt_reg <= wait_cnt_next;
      tmr_we_n     <= tmr_we_n_next;
      tmr_a        <= tmr_a_next;
      tmr_di       <= tmr_di_next;
      m0_ack       <= ack_next[0];
      m1_ack       <= ack_next[1];
      busy         <= busy_next;
      if (rdata_load[0]) begin
        m0_rdata <= tmr_do;
      end
      if (rdata_load[1]) begin
        m1_rdata <= tmr_do;
      end
    end
  end

endmodule

// File: tb/tb_timer_bus_arbiter.sv
// tb_timer_bus_arbiter
//   Drives the arbiter with a small timer model (DO = registered count XOR
//   address) and checks bus sequencing, latency, arbitration order, strict
//   priority, back-to-back issue and mid-access reset.
module tb_timer_bus_arbiter;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       m0_req = 1'b0, m0_we_n = 1'b1;
  logic [2:0] m0_addr = 3'd0;
  logic [7:0] m0_wdata = 8'h00;
  logic       m0_ack;
  logic [7:0] m0_rdata;
  logic       m1_req = 1'b0, m1_we_n = 1'b1;
  logic [2:0] m1_addr = 3'd0;
  logic [7:0] m1_wdata = 8'h00;
  logic       m1_ack;
  logic [7:0] m1_rdata;
  logic       tmr_we_n;
  logic [2:0] tmr_a;
  logic [7:0] tmr_di;
  logic [7:0] tmr_do;
  logic       busy, grant_id;

  // strict-priority instance
  logic       s_m0_req = 1'b0, s_m1_req = 1'b0;
  logic       s_we_n = 1'b1;
  logic [2:0] s_addr = 3'b001;
  logic [7:0] s_wdata = 8'h00;
  logic [7:0] s_tmr_do = 8'h3C;
  logic       s_m0_ack, s_m1_ack;
  logic [7:0] s_m0_rdata, s_m1_rdata;
  logic       s_tmr_we_n;
  logic [2:0] s_tmr_a;
  logic [7:0] s_tmr_di;
  logic       s_busy, s_grant_id;

  int          checks = 0;
  int          errors = 0;
  int unsigned cyc = 0;
  logic [7:0]  tmr_regs [8];

  typedef struct packed {
    logic       id;
    logic       is_rd;
    logic [7:0] rdata;
  } exp_t;

  exp_t sb_q[$];

  timer_bus_arbiter #(.MAX_WAIT(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .m0_req(m0_req), .m0_we_n(m0_we_n), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_ack(m0_ack), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_we_n(m1_we_n), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_ack(m1_ack), .m1_rdata(m1_rdata),
    .tmr_we_n(tmr_we_n), .tmr_a(tmr_a), .tmr_di(tmr_di), .tmr_do(tmr_do),
    .busy(busy), .grant_id(grant_id)
  );

  timer_bus_arbiter #(.MAX_WAIT(0)) dut_strict (
    .clk(clk), .rst_n(rst_n),
    .m0_req(s_m0_req), .m0_we_n(s_we_n), .m0_addr(s_addr), .m0_wdata(s_wdata),
    .m0_ack(s_m0_ack), .m0_rdata(s_m0_rdata),
    .m1_req(s_m1_req), .m1_we_n(s_we_n), .m1_addr(s_addr), .m1_wdata(s_wdata),
    .m1_ack(s_m1_ack), .m1_rdata(s_m1_rdata),
    .tmr_we_n(s_tmr_we_n), .tmr_a(s_tmr_a), .tmr_di(s_tmr_di), .tmr_do(s_tmr_do),
    .busy(s_busy), .grant_id(s_grant_id)
  );

  always #5 clk = ~clk;

  // Timer model: free-running count, DO registered one cycle after A.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (tmr_we_n === 1'b0) tmr_regs[tmr_a] <= tmr_di;
    tmr_do <= cyc[7:0] ^ {tmr_a, 5'b0};
  end

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++; if (tmr_we_n !== 1'b1) begin errors++; $display("FAIL reset_we_n: got %b expected 1", tmr_we_n); end
    checks++; if (tmr_a !== 3'b001) begin errors++; $display("FAIL reset_a: got %0d expected 1", tmr_a); end
    checks++; if (tmr_di !== 8'h00) begin errors++; $display("FAIL reset_di: got %h expected 00", tmr_di); end
    checks++; if ({m0_ack, m1_ack, busy, grant_id} !== 4'b0000) begin errors++; $display("FAIL reset_ctrl: got %b expected 0000", {m0_ack, m1_ack, busy, grant_id}); end
    checks++; if ({m0_rdata, m1_rdata} !== 16'h0000) begin errors++; $display("FAIL reset_rdata: got %h expected 0000", {m0_rdata, m1_rdata}); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    checks++; if (busy !== 1'b0 || tmr_a !== 3'b001) begin errors++; $display("FAIL reset_release: got busy=%b a=%0d expected busy=0 a=1", busy, tmr_a); end
    $display("reset: done");
  endtask

  task automatic test_write();
    exp_t e;
    @(posedge clk); #1;
    m0_we_n = 1'b0; m0_addr = 3'b101; m0_wdata = 8'h10; m0_req = 1'b1;
    sb_q.push_back(exp_t'{1'b0, 1'b0, 8'h00});
    @(negedge clk);  // before E0
    checks++; if (tmr_we_n !== 1'b1) begin errors++; $display("FAIL t1_pre_we: got %b expected 1", tmr_we_n); end
    @(negedge clk);  // between E0 and E1
    checks++; if ({tmr_we_n, tmr_a, tmr_di} !== {1'b0, 3'b101, 8'h10}) begin errors++; $display("FAIL t1_wr_bus: got we=%b a=%0d di=%h expected we=0 a=5 di=10", tmr_we_n, tmr_a, tmr_di); end
    checks++; if (m0_ack !== 1'b0) begin errors++; $display("FAIL t1_early_ack: got %b expected 0", m0_ack); end
    @(negedge clk);  // after E1
    checks++; if (tmr_we_n !== 1'b1 || tmr_a !== 3'b101) begin errors++; $display("FAIL t1_after_we: got we=%b a=%0d expected we=1 a=5", tmr_we_n, tmr_a); end
    checks++; if (m0_ack !== 1'b1 || m1_ack !== 1'b0) begin errors++; $display("FAIL t1_ack: got m0=%b m1=%b expected m0=1 m1=0", m0_ack, m1_ack); end
    if (m0_ack === 1'b1 && sb_q.size() > 0) begin
      e = sb_q.pop_front();
      checks++; if (m1_ack !== e.id) begin errors++; $display("FAIL t1_sb_id: got %b expected %b", m1_ack, e.id); end
    end
    @(posedge clk); #1;
    m0_req = 1'b0; m0_we_n = 1'b1;
    @(negedge clk);
    checks++; if ({m0_ack, busy, grant_id, tmr_we_n} !== 4'b0001) begin errors++; $display("FAIL t1_idle: got ack/busy/gid/we=%b expected 0001", {m0_ack, busy, grant_id, tmr_we_n}); end
    checks++; if (tmr_a !== 3'b101 || tmr_di !== 8'h10) begin errors++; $display("FAIL t1_hold: got a=%0d di=%h expected a=5 di=10", tmr_a, tmr_di); end
    checks++; if (tmr_regs[5] !== 8'h10) begin errors++; $display("FAIL t1_timer_reg: got %h expected 10", tmr_regs[5]); end
    checks++; if (sb_q.size() != 0) begin errors++; $display("FAIL t1_sb_left: got %0d expected 0", sb_q.size()); end
    sb_q.delete();
    $display("t1 write: addr 5 data 10");
  endtask

  task automatic test_read();
    exp_t e;
    int unsigned v;
    @(posedge clk); #1;
    v = cyc;
    m1_we_n = 1'b1; m1_addr = 3'b000; m1_wdata = 8'h77; m1_req = 1'b1;
    sb_q.push_back(exp_t'{1'b1, 1'b1, 8'(v + 1)});
    @(negedge clk);  // before E0
    @(negedge clk);  // after E0
    checks++; if ({busy, tmr_we_n, tmr_a, tmr_di} !== {1'b1, 1'b1, 3'b000, 8'h77}) begin errors++; $display("FAIL t2_rd_bus: got busy=%b we=%b a=%0d di=%h expected 1 1 0 77", busy, tmr_we_n, tmr_a, tmr_di); end
    checks++; if (m0_ack !== 1'b0 || m1_ack !== 1'b0) begin errors++; $display("FAIL t2_early0: got m0=%b m1=%b expected 0 0", m0_ack, m1_ack); end
    @(negedge clk);  // after E1
    checks++; if (m0_ack !== 1'b0 || m1_ack !== 1'b0) begin errors++; $display("FAIL t2_early1: got m0=%b m1=%b expected 0 0", m0_ack, m1_ack); end
    @(negedge clk);  // after E2
    checks++; if (m1_ack !== 1'b1 || m0_ack !== 1'b0 || grant_id !== 1'b1) begin errors++; $display("FAIL t2_ack: got m1=%b m0=%b gid=%b expected 1 0 1", m1_ack, m0_ack, grant_id); end
    if (m1_ack === 1'b1 && sb_q.size() > 0) begin
      e = sb_q.pop_front();
      checks++; if (m1_ack !== e.id || m1_rdata !== e.rdata) begin errors++; $display("FAIL t2_rdata: got id=%b data=%h expected id=%b data=%h", m1_ack, m1_rdata, e.id, e.rdata); end
    end
    @(posedge clk); #1;
    m1_req = 1'b0;
    @(negedge clk);
    checks++; if (m1_ack !== 1'b0 || m0_ack !== 1'b0 || m1_rdata !== 8'(v + 1)) begin errors++; $display("FAIL t2_hold: got m1=%b m0=%b data=%h expected 0 0 %h", m1_ack, m0_ack, m1_rdata, 8'(v + 1)); end
    checks++; if (sb_q.size() != 0) begin errors++; $display("FAIL t2_sb_left: got %0d expected 0", sb_q.size()); end
    sb_q.delete();
    $display("t2 read: m1 addr 0 count %h", 8'(v + 1));
  endtask

  task automatic test_starvation();
    exp_t e;
    int unsigned v;
    int n = 0;
    int cycles = 0;
    logic [2:0] a;
    logic [7:0] got;
    @(posedge clk); #1;
    v = cyc;
    m0_we_n = 1'b1; m0_addr = 3'b001; m1_we_n = 1'b1; m1_addr = 3'b010;
    m0_req = 1'b1; m1_req = 1'b1;
    for (int k = 0; k < 10; k++) begin
      a = (k % 5 == 4) ? 3'b010 : 3'b001;
      sb_q.push_back(exp_t'{(k % 5 == 4), 1'b1, 8'(v + 4 * k + 1) ^ {a, 5'b0}});
    end
    while (n < 10 && cycles < 200) begin
      @(negedge clk);
      cycles++;
      if (m0_ack === 1'b1 || m1_ack === 1'b1) begin
        n++;
        got = m1_ack ? m1_rdata : m0_rdata;
        checks++;
        if (m0_ack === 1'b1 && m1_ack === 1'b1) begin
          errors++; $display("FAIL t3_both_ack: got 11 expected one-hot");
        end else if (sb_q.size() == 0) begin
          errors++; $display("FAIL t3_unexpected: got ack id=%b expected none", m1_ack);
        end else begin
          e = sb_q.pop_front();
          if (m1_ack !== e.id || got !== e.rdata) begin
            errors++; $display("FAIL t3_grant%0d: got id=%b data=%h expected id=%b data=%h", n, m1_ack, got, e.id, e.rdata);
          end else begin
            $display("t3 access %0d: m%0d data %h", n, e.id, got);
          end
        end
      end
    end
    @(posedge clk); #1;
    m0_req = 1'b0; m1_req = 1'b0;
    checks++; if (n != 10) begin errors++; $display("FAIL t3_count: got %0d acks expected 10", n); end
    checks++; if (sb_q.size() != 0) begin errors++; $display("FAIL t3_sb_left: got %0d expected 0", sb_q.size()); end
    sb_q.delete();
  endtask

  task automatic test_strict();
    int n0 = 0;
    int n1 = 0;
    int cycles = 0;
    @(posedge clk); #1;
    s_m0_req = 1'b1; s_m1_req = 1'b1;
    while (n0 + n1 < 20 && cycles < 400) begin
      @(negedge clk);
      cycles++;
      if (s_m0_ack === 1'b1) n0++;
      if (s_m1_ack === 1'b1) n1++;
    end
    @(posedge clk); #1;
    s_m0_req = 1'b0; s_m1_req = 1'b0;
    @(negedge clk);
    checks++; if (n1 != 0) begin errors++; $display("FAIL t4_m1_acks: got %0d expected 0", n1); end
    checks++; if (n0 != 20) begin errors++; $display("FAIL t4_m0_acks: got %0d expected 20", n0); end
    checks++; if (s_busy !== 1'b0 || s_grant_id !== 1'b0) begin errors++; $display("FAIL t4_idle: got busy=%b gid=%b expected 0 0", s_busy, s_grant_id); end
    checks++; if (s_m0_rdata !== 8'h3C || s_m1_rdata !== 8'h00) begin errors++; $display("FAIL t4_rdata: got m0=%h m1=%h expected 3c 00", s_m0_rdata, s_m1_rdata); end
    checks++; if ({s_tmr_we_n, s_tmr_a, s_tmr_di} !== {1'b1, 3'b001, 8'h00}) begin errors++; $display("FAIL t4_bus: got we=%b a=%0d di=%h expected 1 1 00", s_tmr_we_n, s_tmr_a, s_tmr_di); end
    $display("t4 strict: m0 acks %0d m1 acks %0d", n0, n1);
  endtask

  task automatic test_back_to_back();
    exp_t e;
    int pulses = 0;
    int cycles;
    logic got;
    @(posedge clk); #1;
    m0_we_n = 1'b0; m0_addr = 3'b011; m0_wdata = 8'hC3; m0_req = 1'b1;
    sb_q.push_back(exp_t'{1'b0, 1'b0, 8'h00});
    sb_q.push_back(exp_t'{1'b0, 1'b0, 8'h00});
    for (int p = 0; p < 2; p++) begin
      cycles = 0;
      got = 1'b0;
      while (!got && cycles < 20) begin
        @(negedge clk);
        cycles++;
        if (m0_ack === 1'b1) got = 1'b1;
      end
      checks++;
      if (!got) begin
        errors++; $display("FAIL t5_ack%0d: got no ack expected ack", p);
      end else begin
        pulses++;
        e = sb_q.pop_front();
        if (m1_ack !== e.id) begin errors++; $display("FAIL t5_id%0d: got %b expected %b", p, m1_ack, e.id); end
      end
      @(posedge clk);
      if (p == 1) begin
        #1;
        m0_req = 1'b0; m0_we_n = 1'b1;
      end
      @(negedge clk);
      checks++; if (busy !== 1'b0 || m0_ack !== 1'b0) begin errors++; $display("FAIL t5_gap%0d: got busy=%b ack=%b expected 0 0", p, busy, m0_ack); end
      @(negedge clk);
      checks++; if (busy !== (p == 0)) begin errors++; $display("FAIL t5_after%0d: got busy=%b expected %b", p, busy, (p == 0)); end
      $display("t5 access %0d: m0 ack seen", p);
    end
    repeat (8) begin
      @(negedge clk);
      if (m0_ack === 1'b1) pulses++;
    end
    checks++; if (pulses != 2) begin errors++; $display("FAIL t5_pulses: got %0d expected 2", pulses); end
    checks++; if (tmr_regs[3] !== 8'hC3) begin errors++; $display("FAIL t5_timer_reg: got %h expected c3", tmr_regs[3]); end
    sb_q.delete();
  endtask

  task automatic test_reset_mid();
    int acks = 0;
    @(posedge clk); #1;
    m0_we_n = 1'b1; m0_addr = 3'b011; m0_wdata = 8'hEE; m0_req = 1'b1;
    sb_q.push_back(exp_t'{1'b0, 1'b1, 8'h00});
    @(negedge clk);  // before E0
    @(negedge clk);  // RD_ADDR
    @(negedge clk);  // RD_WAIT
    checks++; if (busy !== 1'b1 || m0_ack !== 1'b0 || tmr_di !== 8'hEE) begin errors++; $display("FAIL t6_pre: got busy=%b ack=%b di=%h expected 1 0 ee", busy, m0_ack, tmr_di); end
    #1;
    rst_n = 1'b0;
    #1;
    checks++; if ({m0_ack, m1_ack, busy, grant_id, tmr_we_n} !== 5'b00001) begin errors++; $display("FAIL t6_ctrl: got %b expected 00001", {m0_ack, m1_ack, busy, grant_id, tmr_we_n}); end
    checks++; if (tmr_a !== 3'b001 || tmr_di !== 8'h00) begin errors++; $display("FAIL t6_bus: got a=%0d di=%h expected 1 00", tmr_a, tmr_di); end
    checks++; if (m0_rdata !== 8'h00 || m1_rdata !== 8'h00) begin errors++; $display("FAIL t6_rdata: got m0=%h m1=%h expected 00 00", m0_rdata, m1_rdata); end
    m0_req = 1'b0;
    sb_q.delete();
    repeat (3) begin
      @(negedge clk);
      if (m0_ack === 1'b1 || m1_ack === 1'b1) acks++;
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      if (m0_ack === 1'b1 || m1_ack === 1'b1) acks++;
    end
    checks++; if (acks != 0) begin errors++; $display("FAIL t6_no_ack: got %0d acks expected 0", acks); end
    checks++; if (busy !== 1'b0 || m0_rdata !== 8'h00) begin errors++; $display("FAIL t6_after: got busy=%b rdata=%h expected 0 00", busy, m0_rdata); end
    $display("t6 reset mid-read: abandoned");
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_starvation();
    test_strict();
    test_back_to_back();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
